// File: rtl/video_timing_pkg.sv
// Shared types and default 640x480@60 timing for the video timing controller.
package video_timing_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_STOP
  } state_e;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FRONT  = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BACK   = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FRONT  = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BACK   = 33;

endpackage

// File: rtl/timing_delay_pipe.sv
// Fixed-depth shift register that lines sync/blank up with returned pixel data.
module timing_delay_pipe #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] rst_val,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [DEPTH-1:0][WIDTH-1:0] stage;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage <= {DEPTH{rst_val}};
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/video_timing_ctrl.sv
// Raster timing generator: pixel fetch requests plus sync/blank delayed to match
// the fetch latency. Frames always run to completion once started.
module video_timing_ctrl
  import video_timing_pkg::*;
#(
  parameter int   p_h_active     = VGA_H_ACTIVE,
  parameter int   p_h_front      = VGA_H_FRONT,
  parameter int   p_h_sync       = VGA_H_SYNC,
  parameter int   p_h_back       = VGA_H_BACK,
  parameter int   p_v_active     = VGA_V_ACTIVE,
  parameter int   p_v_front      = VGA_V_FRONT,
  parameter int   p_v_sync       = VGA_V_SYNC,
  parameter int   p_v_back       = VGA_V_BACK,
  parameter logic p_h_sync_pol   = 1'b0,
  parameter logic p_v_sync_pol   = 1'b0,
  parameter int   p_data_latency = 2
) (
  input  logic                          i_clk_pixel,
  input  logic                          i_rst,
  input  logic                          i_en,
  output logic                          o_req,
  output logic [$clog2(p_h_active)-1:0] o_x,
  output logic [$clog2(p_v_active)-1:0] o_y,
  output logic                          o_frame_start,
  output logic                          o_line_start,
  output logic                          o_hsync,
  output logic                          o_vsync,
  output logic                          o_blank,
  output logic                          o_busy
);

  localparam int H_TOTAL = p_h_active + p_h_front + p_h_sync + p_h_back;
  localparam int V_TOTAL = p_v_active + p_v_front + p_v_sync + p_v_back;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int XW = $clog2(p_h_active);
  localparam int YW = $clog2(p_v_active);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(p_h_active);
  localparam logic [HW-1:0] H_SYNC_S = HW'(p_h_active + p_h_front);
  localparam logic [HW-1:0] H_SYNC_E = HW'(p_h_active + p_h_front + p_h_sync);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(p_v_active);
  localparam logic [VW-1:0] V_SYNC_S = VW'(p_v_active + p_v_front);
  localparam logic [VW-1:0] V_SYNC_E = VW'(p_v_active + p_v_front + p_v_sync);

  if (p_h_active <= 0 || p_h_front <= 0 || p_h_sync <= 0 || p_h_back <= 0 ||
      p_v_active <= 0 || p_v_front <= 0 || p_v_sync <= 0 || p_v_back <= 0 ||
      p_data_latency < 1 || p_data_latency > 8) begin : g_bad_param
    $error("video_timing_ctrl: illegal timing parameter");
  end

  state_e                    state, state_nxt;
  logic [HW-1:0]             h;
  logic [VW-1:0]             v;
  logic                      running, frame_last, pix_act;
  logic                      req_hs, req_vs, req_blank;
  logic [p_data_latency-1:0] vld_pipe;
  logic [2:0]                pipe_q;

  assign running    = (state != ST_IDLE);
  assign frame_last = (h == H_LAST) && (v == V_LAST);
  assign pix_act    = running && (h < H_ACT) && (v < V_ACT);

  always_ff @(posedge i_clk_pixel) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // STOP keeps the raster moving; only the last cycle of a frame may drop to IDLE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:         if (i_en) state_nxt = ST_RUN;
      ST_RUN, ST_STOP: begin
        if (i_en)            state_nxt = ST_RUN;
        else if (frame_last) state_nxt = ST_IDLE;
        else                 state_nxt = ST_STOP;
      end
      default:         state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk_pixel) begin
    if (i_rst || !running) begin
      h <= '0;
      v <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

  // Request stage: one register behind the counters.
  always_ff @(posedge i_clk_pixel) begin
    if (i_rst) begin
      o_req         <= 1'b0;
      o_x           <= '0;
      o_y           <= '0;
      o_frame_start <= 1'b0;
      o_line_start  <= 1'b0;
      req_hs        <= ~p_h_sync_pol;
      req_vs        <= ~p_v_sync_pol;
      req_blank     <= 1'b1;
    end else begin
      o_req         <= pix_act;
      if (pix_act) begin
        o_x <= h[XW-1:0];
        o_y <= v[YW-1:0];
      end
      o_frame_start <= pix_act && (h == '0) && (v == '0);
      o_line_start  <= pix_act && (h == '0);
      req_hs        <= (running && h >= H_SYNC_S && h < H_SYNC_E) ? p_h_sync_pol : ~p_h_sync_pol;
      req_vs        <= (running && v >= V_SYNC_S && v < V_SYNC_E) ? p_v_sync_pol : ~p_v_sync_pol;
      req_blank     <= ~pix_act;
    end
  end

  timing_delay_pipe #(
    .DEPTH (p_data_latency),
    .WIDTH (3)
  ) u_delay (
    .clk     (i_clk_pixel),
    .rst     (i_rst),
    .rst_val ({~p_h_sync_pol, ~p_v_sync_pol, 1'b1}),
    .d       ({req_hs, req_vs, req_blank}),
    .q       (pipe_q)
  );

  assign {o_hsync, o_vsync, o_blank} = pipe_q;

  // Tracks frame content still travelling toward the outputs after IDLE.
  always_ff @(posedge i_clk_pixel) begin
    if (i_rst) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= running;
      for (int i = 1; i < p_data_latency; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  assign o_busy = running | (|vld_pipe);

endmodule
